prga: RTL and testbench

- Pseudo-random generation stage of the ARC4 datapath. Sits directly downstream of the key-scheduling stage.
- Consumes the key-scheduled S array (256x8 on-chip RAM), keystreams a length-prefixed ciphertext RAM and writes a length-prefixed plaintext RAM.
- The top-level controller starts it with the en/rdy handshake once key scheduling reports rdy.

---
 rtl/prga.sv | 162 ++++++++++++++++
 tb/tb_prga.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prga.sv
`default_nettype none
// ============================================================================
//  Module   : prga
//  Purpose  : ARC4 pseudo-random generation stage. Walks the key-scheduled
//             S array, swaps S[i]/S[j] per byte, and XORs the resulting pad
//             with a length-prefixed ciphertext to build the plaintext.
//  Revision : 1.0  initial release
// ============================================================================
module prga #(
  parameter logic [7:0] LEN_ADDR = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_LEN   = 4'd1,
    WAIT_LEN = 4'd2,
    WR_LEN   = 4'd3,
    RD_SI    = 4'd4,
    WAIT_SI  = 4'd5,
    RD_SJ    = 4'd6,
    WAIT_SJ  = 4'd7,
    WR_SI    = 4'd8,
    WR_SJ    = 4'd9,
    RD_PAD   = 4'd10,
    WAIT_PAD = 4'd11,
    WR_PT    = 4'd12
  } state_t;

  state_t     state;
  logic [7:0] i;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] len;
  logic [7:0] si;
  logic [7:0] sj;

  // Single FSM. All RAM-facing outputs are registered, so each output is
  // loaded on the edge that enters the state it belongs to. RAM read data is
  // sampled during the WAIT state that follows each read, while the address
  // is still held, which is the same value seen by the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      ct_addr   <= 8'd0;
      pt_addr   <= 8'd0;
      pt_wrdata <= 8'd0;
      pt_wren   <= 1'b0;
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 8'd0;
      len       <= 8'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
    end else begin
      // Write enables are single-cycle pulses; the write states re-assert them.
      s_wren  <= 1'b0;
      pt_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state   <= RD_LEN;
            rdy     <= 1'b0;
            ct_addr <= LEN_ADDR;
          end
        end
        RD_LEN: state <= WAIT_LEN;
        WAIT_LEN: begin
          // Length byte is on ct_rddata now; copy it straight to pt.
          state     <= WR_LEN;
          len       <= ct_rddata;
          i         <= 8'd0;
          j         <= 8'd0;
          k         <= 8'd1;
          pt_addr   <= LEN_ADDR;
          pt_wrdata <= ct_rddata;
          pt_wren   <= 1'b1;
        end
        WR_LEN: begin
          if (len == 8'd0) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end else begin
            state  <= RD_SI;
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
          end
        end
        RD_SI: state <= WAIT_SI;
        WAIT_SI: begin
          // s_rddata holds S[i]; j advances by it and S[j] is fetched next.
          state  <= RD_SJ;
          si     <= s_rddata;
          j      <= j + s_rddata;
          s_addr <= j + s_rddata;
        end
        RD_SJ: state <= WAIT_SJ;
        WAIT_SJ: begin
          // S[j] is available: start the swap by writing it to S[i].
          state    <= WR_SI;
          sj       <= s_rddata;
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
        end
        WR_SI: begin
          // When i == j this rewrites the original S[i], undoing the first write.
          state    <= WR_SJ;
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
        end
        WR_SJ: begin
          state   <= RD_PAD;
          s_addr  <= si + sj;
          ct_addr <= LEN_ADDR + k;
        end
        RD_PAD: state <= WAIT_PAD;
        WAIT_PAD: begin
          state     <= WR_PT;
          pt_addr   <= LEN_ADDR + k;
          pt_wrdata <= s_rddata ^ ct_rddata;
          pt_wren   <= 1'b1;
        end
        WR_PT: begin
          if (k == len) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end else begin
            state  <= RD_SI;
            k      <= k + 8'd1;
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prga.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prga
//  Purpose  : Self-checking bench for prga with behavioural S/ct/pt RAMs and
//             a software ARC4 reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prga;

  localparam int BOUND = 2600;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  // Bench-side write port used to preload the RAMs between runs.
  logic       tb_we;
  int         tb_sel;
  logic [7:0] tb_waddr, tb_wdata;

  logic [7:0] s_mem  [0:255];
  logic [7:0] ct_mem [0:255];
  logic [7:0] pt_mem [0:255];
  logic [7:0] ct_img [0:255];
  logic [7:0] m_s    [0:255];
  logic [7:0] exp_pt [0:255];

  int errors = 0;
  int checks = 0;
  int s_wr_cnt = 0;
  int both_cnt = 0;

  typedef struct {
    logic [31:0] ct;
    logic [31:0] pt;
    int          lat;
    int          swr;
  } vec_t;

  vec_t vecs [5];

  prga #(.LEN_ADDR(8'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM models with a bench preload port.
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (tb_we && tb_sel == 0) s_mem[tb_waddr] <= tb_wdata;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (tb_we && tb_sel == 1) ct_mem[tb_waddr] <= tb_wdata;
    if (tb_we && tb_sel == 2) pt_mem[tb_waddr] <= tb_wdata;
    else if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
  end

  // Count S writes and cycles with both write enables high.
  always @(negedge clk) begin
    if (s_wren === 1'b1) s_wr_cnt++;
    if (s_wren === 1'b1 && pt_wren === 1'b1) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tb_write(input int sel, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_sel = sel; tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
  endtask

  task automatic tb_done();
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) tb_write(0, 8'(x), 8'(x));
    tb_done();
  endtask

  task automatic load_small(input logic [31:0] ct);
    for (int x = 0; x < 4; x++) begin
      tb_write(1, 8'(x), ct[31-8*x -: 8]);
      tb_write(2, 8'(x), 8'hEE);
    end
    tb_done();
  endtask

  // Pulse en for one cycle and count edges from E0 until rdy returns.
  task automatic run_dut(output int lat);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    lat = 0;
    while (rdy !== 1'b1 && lat < BOUND) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  function automatic logic [31:0] pt_word();
    return {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]};
  endfunction

  task automatic model_ksa();
    logic [7:0] key [3];
    logic [7:0] jj, t;
    key[0] = 8'h00; key[1] = 8'h03; key[2] = 8'h3C;
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    jj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + m_s[x] + key[x % 3];
      t = m_s[x]; m_s[x] = m_s[jj]; m_s[jj] = t;
    end
  endtask

  task automatic model_prga(input int n);
    logic [7:0] ii, jj, t;
    ii = 8'd0; jj = 8'd0;
    for (int x = 1; x <= n; x++) begin
      ii = ii + 8'd1;
      jj = jj + m_s[ii];
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      t = m_s[ii] + m_s[jj];
      exp_pt[x] = ct_img[x] ^ m_s[t];
    end
  endtask

  initial begin
    int lat, sw0, bad;
    rst = 1'b1; en = 1'b0; tb_we = 1'b0; tb_sel = 0; tb_waddr = 8'd0; tb_wdata = 8'd0;

    vecs[0] = '{ct: 32'h03_00_00_00, pt: 32'h03_02_05_07, lat: 30, swr: 6};
    vecs[1] = '{ct: 32'h03_AA_55_FF, pt: 32'h03_A8_50_F8, lat: 30, swr: 6};
    vecs[2] = '{ct: 32'h00_12_34_56, pt: 32'h00_EE_EE_EE, lat: 3,  swr: 0};
    vecs[3] = '{ct: 32'h01_10_00_00, pt: 32'h01_12_EE_EE, lat: 12, swr: 2};
    vecs[4] = '{ct: 32'h02_01_80_00, pt: 32'h02_03_85_EE, lat: 21, swr: 4};

    #1;
    check("reset rdy", 32'(rdy), 32'd1);
    check("reset wren", {30'd0, s_wren, pt_wren}, 32'd0);
    check("reset addrs", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
    check("reset wrdata", {16'd0, s_wrdata, pt_wrdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven runs on an identity S array.
    for (int v = 0; v < 5; v++) begin
      load_identity();
      load_small(vecs[v].ct);
      sw0 = s_wr_cnt;
      run_dut(lat);
      check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].lat));
      check($sformatf("vec%0d pt", v), pt_word(), vecs[v].pt);
      check($sformatf("vec%0d s_wren cycles", v), 32'(s_wr_cnt - sw0), 32'(vecs[v].swr));
      if (v == 0)
        check("vec0 final S", {s_mem[2], s_mem[3], s_mem[5], s_mem[4]}, 32'h03_05_02_04);
    end

    // en held high in IDLE restarts immediately after rdy returns.
    load_small(32'h00_00_00_00);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    check("held en busy", 32'(rdy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("held en rdy back", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    check("held en restart", 32'(rdy), 32'd0);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held en second done", 32'(rdy), 32'd1);

    // en held for 5 cycles then pulsed again while busy: no restart.
    load_identity();
    load_small(32'h03_AA_55_FF);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (rdy !== 1'b1 && lat < BOUND) begin
      en = (lat < 5 || lat == 10 || lat == 11);
      @(posedge clk); #1;
      lat++;
    end
    en = 1'b0;
    check("busy en latency", 32'(lat), 32'd30);
    check("busy en pt", pt_word(), 32'h03_A8_50_F8);
    @(posedge clk); #1;
    check("busy en stays idle", 32'(rdy), 32'd1);

    // Asynchronous reset during RD_SJ of byte 2 (E0 + 14).
    load_identity();
    load_small(32'h03_00_00_00);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    check("pre-reset rdy", 32'(rdy), 32'd0);
    rst = 1'b1;
    #1;
    check("async reset rdy", 32'(rdy), 32'd1);
    check("async reset wren", {30'd0, s_wren, pt_wren}, 32'd0);
    check("async reset addrs", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    load_identity();
    load_small(32'h03_00_00_00);
    run_dut(lat);
    check("post-reset latency", 32'(lat), 32'd30);
    check("post-reset pt", pt_word(), 32'h03_02_05_07);

    // Full-length message against the software model, key 0x00033C.
    model_ksa();
    for (int x = 0; x < 256; x++) tb_write(0, 8'(x), m_s[x]);
    ct_img[0] = 8'd255;
    for (int x = 1; x < 256; x++) ct_img[x] = 8'(x * 13 + 7);
    for (int x = 0; x < 256; x++) tb_write(1, 8'(x), ct_img[x]);
    tb_done();
    model_prga(255);
    sw0 = s_wr_cnt;
    run_dut(lat);
    check("len255 latency", 32'(lat), 32'd2298);
    check("len255 pt[0]", 32'(pt_mem[0]), 32'd255);
    bad = 0;
    for (int x = 1; x < 256; x++) if (pt_mem[x] !== exp_pt[x]) bad++;
    check("len255 pt bytes wrong", 32'(bad), 32'd0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
    check("len255 final S wrong", 32'(bad), 32'd0);
    check("len255 s_wren cycles", 32'(s_wr_cnt - sw0), 32'd510);

    check("both wren cycles", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
